// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display encoder and the readback decoder.
// Patterns are active-low a..g in bits 6..0 with bit 7 always 0, except blank.
package seg7_pkg;

   localparam logic [7:0] SEG_0     = 8'h01;
   localparam logic [7:0] SEG_1     = 8'h4F;
   localparam logic [7:0] SEG_2     = 8'h12;
   localparam logic [7:0] SEG_3     = 8'h06;
   localparam logic [7:0] SEG_4     = 8'h4C;
   localparam logic [7:0] SEG_5     = 8'h24;
   localparam logic [7:0] SEG_6     = 8'h20;
   localparam logic [7:0] SEG_7     = 8'h0F;
   localparam logic [7:0] SEG_8     = 8'h00;
   localparam logic [7:0] SEG_9     = 8'h04;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      PAIR_VALID,
      PAIR_BLANK,
      PAIR_INVALID
   } pair_class_t;

   typedef enum logic {
      ST_TRACK,
      ST_LOCKED
   } dec_state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational seven-segment pattern to BCD digit decoder.
// Only exact pattern matches are legal; blank is reported separately.
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [7:0] seg_i,
   output logic [3:0] digit_o,
   output logic       legal_o,
   output logic       blank_o
);

   always_comb begin
      digit_o = 4'd0;
      legal_o = 1'b1;
      blank_o = (seg_i == SEG_BLANK);
      case (seg_i)
         SEG_0:   digit_o = 4'd0;
         SEG_1:   digit_o = 4'd1;
         SEG_2:   digit_o = 4'd2;
         SEG_3:   digit_o = 4'd3;
         SEG_4:   digit_o = 4'd4;
         SEG_5:   digit_o = 4'd5;
         SEG_6:   digit_o = 4'd6;
         SEG_7:   digit_o = 4'd7;
         SEG_8:   digit_o = 4'd8;
         SEG_9:   digit_o = 4'd9;
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Display readback monitor: decodes two seven-segment buses back into 0..63 once
// the pattern pair has been stable for STABLE_CYCLES, and counts illegal pairs.
module seg_pattern_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] led0,
   input  logic [7:0] led1,
   input  logic       clr_err,
   output logic [5:0] num,
   output logic       num_valid,
   output logic       update,
   output logic       err,
   output logic [7:0] err_cnt
);

   localparam int               CNT_W   = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [7:0]       smp0_q, smp1_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dec_state_t       state_q;
   logic [5:0]       num_q;
   logic             num_valid_q, update_q, err_q;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic [3:0]  tens, units;
   logic        tens_legal, units_legal, tens_blank, units_blank;
   logic [6:0]  value7;
   logic [5:0]  value6;
   pair_class_t pair_class;
   logic        same, accept;

   seg7_digit_decode u_dec_tens (
      .seg_i   (smp0_q),
      .digit_o (tens),
      .legal_o (tens_legal),
      .blank_o (tens_blank)
   );

   seg7_digit_decode u_dec_units (
      .seg_i   (smp1_q),
      .digit_o (units),
      .legal_o (units_legal),
      .blank_o (units_blank)
   );

   // Range check on the full 7-bit value before dropping to the 6-bit output.
   assign value7 = ({3'b000, tens} * 7'd10) + {3'b000, units};
   assign value6 = value7[5:0];

   always_comb begin
      pair_class = PAIR_INVALID;
      if (tens_blank && units_blank) begin
         pair_class = PAIR_BLANK;
      end else if (tens_legal && units_legal && (value7 <= 7'd63)) begin
         pair_class = PAIR_VALID;
      end
   end

   assign same   = (led0 == smp0_q) && (led1 == smp1_q);
   assign accept = (state_q == ST_TRACK) && same && (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q;
      if (!same) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Clear takes priority over a coincident increment.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (clr_err) begin
         err_cnt_d = 8'd0;
      end else if (accept && (pair_class == PAIR_INVALID) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp0_q      <= SEG_BLANK;
         smp1_q      <= SEG_BLANK;
         cnt_q       <= '0;
         state_q     <= ST_TRACK;
         num_q       <= 6'd0;
         num_valid_q <= 1'b0;
         update_q    <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= 8'd0;
      end else begin
         smp0_q    <= led0;
         smp1_q    <= led1;
         cnt_q     <= cnt_d;
         err_cnt_q <= err_cnt_d;
         update_q  <= 1'b0;
         err_q     <= 1'b0;
         if (state_q == ST_TRACK) begin
            if (accept) begin
               state_q <= ST_LOCKED;
               case (pair_class)
                  PAIR_VALID: begin
                     num_q       <= value6;
                     num_valid_q <= 1'b1;
                     update_q    <= !num_valid_q || (value6 != num_q);
                  end
                  PAIR_BLANK: begin
                     num_valid_q <= 1'b0;
                  end
                  default: begin
                     num_valid_q <= 1'b0;
                     err_q       <= 1'b1;
                  end
               endcase
            end
         end else if (!same) begin
            state_q <= ST_TRACK;
         end
      end
   end

   assign num       = num_q;
   assign num_valid = num_valid_q;
   assign update    = update_q;
   assign err       = err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Bench for seg_pattern_decoder with STABLE_CYCLES = 4: vector table plus
// hand-written sequences; update/err pulses are matched against a queue.
module tb_seg_pattern_decoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] led0, led1;
   logic       clr_err;
   logic [5:0] num;
   logic       num_valid, update, err;
   logic [7:0] err_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         is_err;
      logic [5:0] num;
      logic [7:0] cnt;
   } ev_t;

   typedef struct {
      logic [7:0] l0;
      logic [7:0] l1;
      bit         upd;
      bit         er;
      logic [5:0] n;
      bit         v;
      logic [7:0] ec;
   } vec_t;

   ev_t  q[$];
   vec_t tbl[13];

   seg_pattern_decoder #(.STABLE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .led0      (led0),
      .led1      (led1),
      .clr_err   (clr_err),
      .num       (num),
      .num_valid (num_valid),
      .update    (update),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Every pulse must match the oldest expected event.
   always begin : mon
      ev_t e;
      @(posedge clk);
      #1;
      if (rst_n && (update || err)) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse update=%0d err=%0d num=%0d err_cnt=%0d",
                     update, err, num, err_cnt);
         end else begin
            e = q.pop_front();
            if ((update !== !e.is_err) || (err !== e.is_err) ||
                (num !== e.num) || (err_cnt !== e.cnt)) begin
               errors++;
               $display("FAIL pulse update=%0d err=%0d num=%0d err_cnt=%0d expected is_err=%0d num=%0d err_cnt=%0d",
                        update, err, num, err_cnt, e.is_err, e.num, e.cnt);
            end
         end
      end
   end

   // Called at a negedge; drives the pair and holds it through acceptance.
   task automatic apply(input logic [7:0] a, input logic [7:0] b, input bit upd, input bit er,
                        input logic [5:0] n, input bit v, input logic [7:0] ec);
      ev_t ev;
      led0 = a;
      led1 = b;
      if (upd || er) begin
         ev.is_err = er;
         ev.num    = n;
         ev.cnt    = ec;
         q.push_back(ev);
      end
      repeat (4) @(negedge clk);
      chk("not_early", q.size(), (upd || er) ? 1 : 0);
      @(negedge clk);
      chk("num", num, n);
      chk("num_valid", num_valid, v);
      chk("err_cnt", err_cnt, ec);
      chk("pulse_seen", q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int ecnt;
      ev_t ev;
      tbl[0]  = '{8'h06, 8'h24, 1'b1, 1'b0, 6'd35, 1'b1, 8'd0};
      tbl[1]  = '{8'h20, 8'h04, 1'b0, 1'b1, 6'd35, 1'b0, 8'd1};
      tbl[2]  = '{8'h7E, 8'hFF, 1'b0, 1'b1, 6'd35, 1'b0, 8'd2};
      tbl[3]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 6'd35, 1'b0, 8'd2};
      tbl[4]  = '{8'h06, 8'h24, 1'b1, 1'b0, 6'd35, 1'b1, 8'd2};
      tbl[5]  = '{8'h12, 8'h00, 1'b1, 1'b0, 6'd28, 1'b1, 8'd2};
      tbl[6]  = '{8'h20, 8'h06, 1'b1, 1'b0, 6'd63, 1'b1, 8'd2};
      tbl[7]  = '{8'h20, 8'h4C, 1'b0, 1'b1, 6'd63, 1'b0, 8'd3};
      tbl[8]  = '{8'h01, 8'h01, 1'b1, 1'b0, 6'd0,  1'b1, 8'd3};
      tbl[9]  = '{8'h01, 8'hFF, 1'b0, 1'b1, 6'd0,  1'b0, 8'd4};
      tbl[10] = '{8'h4F, 8'h0F, 1'b1, 1'b0, 6'd17, 1'b1, 8'd4};
      tbl[11] = '{8'h0F, 8'h01, 1'b0, 1'b1, 6'd17, 1'b0, 8'd5};
      tbl[12] = '{8'h4F, 8'h0F, 1'b1, 1'b0, 6'd17, 1'b1, 8'd5};

      rst_n   = 1'b0;
      led0    = 8'hFF;
      led1    = 8'hFF;
      clr_err = 1'b0;
      #2;
      chk("rst_num", num, 0);
      chk("rst_num_valid", num_valid, 0);
      chk("rst_update", update, 0);
      chk("rst_err", err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("blank_after_reset_valid", num_valid, 0);
      chk("blank_after_reset_err_cnt", err_cnt, 0);

      for (int i = 0; i < 13; i++) begin
         apply(tbl[i].l0, tbl[i].l1, tbl[i].upd, tbl[i].er, tbl[i].n, tbl[i].v, tbl[i].ec);
      end

      // Re-accepting the value already shown must not pulse update.
      led1 = 8'h0E;
      @(negedge clk);
      led1 = 8'h0F;
      repeat (7) @(negedge clk);
      chk("same_value_num", num, 17);
      chk("same_value_valid", num_valid, 1);

      // Inputs that never settle long enough produce no acceptance.
      led0 = 8'h06;
      for (int t = 0; t < 5; t++) begin
         led1 = t[0] ? 8'h20 : 8'h24;
         repeat (2) @(negedge clk);
      end
      chk("toggle_num", num, 17);
      chk("toggle_valid", num_valid, 1);
      apply(8'h06, 8'h20, 1'b1, 1'b0, 6'd36, 1'b1, 8'd5);

      ecnt = 5;
      for (int k = 0; k < 255; k++) begin
         if (ecnt < 255) ecnt++;
         apply(k[0] ? 8'h7D : 8'h7E, 8'h7E, 1'b0, 1'b1, 6'd36, 1'b0, ecnt[7:0]);
      end
      chk("saturated", err_cnt, 255);

      // Clear coinciding with an increment: pulse still fires, count ends at 0.
      led0 = 8'h20;
      led1 = 8'h04;
      ev.is_err = 1'b1;
      ev.num    = 6'd36;
      ev.cnt    = 8'd0;
      q.push_back(ev);
      repeat (4) @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_wins", err_cnt, 0);
      chk("clr_pulse_seen", q.size(), 0);
      repeat (2) @(negedge clk);

      apply(8'h06, 8'h24, 1'b1, 1'b0, 6'd35, 1'b1, 8'd0);

      // Reset in the middle of a count.
      led0 = 8'h12;
      led1 = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_num", num, 0);
      chk("midrst_valid", num_valid, 0);
      chk("midrst_update", update, 0);
      chk("midrst_err", err, 0);
      chk("midrst_err_cnt", err_cnt, 0);
      led0 = 8'hFF;
      led1 = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_rst_valid", num_valid, 0);
      apply(8'h06, 8'h24, 1'b1, 1'b0, 6'd35, 1'b1, 8'd0);

      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_pattern_decoder.md
# seg_pattern_decoder

Decodes the two active-low seven-segment drive buses (tens digit, units digit) back into the 6-bit value they display, with a stability filter so only patterns held for a programmable number of cycles are accepted. It is the receive-side counterpart of the number-to-segment display encoder in the traffic-light design. It serves as an on-chip display readback/self-test monitor. It flags any illegal segment pattern or out-of-range value and keeps a saturating count of such errors.

## Interface
- STABLE_CYCLES, default 4: consecutive cycles a pattern pair must stay unchanged before acceptance; legal range 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- led0  in  8  tens-digit segment pattern; bit7 = 0, bits6..0 = a..g, active-low.
- led1  in  8  units-digit segment pattern; same format as led0.
- clr_err  in  1  synchronous clear of err_cnt.
- num  out  6  last accepted valid value, 0..63.
- num_valid  out  1  level; 1 while num reflects the most recently accepted pattern pair.
- update  out  1  one-cycle pulse when a valid value is accepted that differs from the previous one, or is accepted after num_valid was 0.
- err  out  1  one-cycle pulse when an invalid pattern pair is accepted.
- err_cnt  out  8  count of accepted invalid pairs; saturates at 255.

## Operation
- Legal digit patterns, exact 8-bit match:
  - 0 = 0x01, 1 = 0x4F, 2 = 0x12, 3 = 0x06, 4 = 0x4C
  - 5 = 0x24, 6 = 0x20, 7 = 0x0F, 8 = 0x00, 9 = 0x04
  - Blank = 0xFF. Any other pattern is illegal.
- Pair classification:
  - BLANK: both buses 0xFF.
  - VALID: both digits legal, and value = tens*10 + units ≤ 63 (tens ≤ 6; tens = 6 requires units ≤ 3). Compute value in 7 bits, then truncate to 6 bits after the range check.
  - INVALID: everything else, including a single blank digit.
- Sample registers smp0/smp1 load led0/led1 every cycle.
- Stability counter cnt (width = clog2(STABLE_CYCLES) + 1):
  - Cleared when {led0, led1} != {smp0, smp1}.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- FSM states: TRACK, LOCKED.
  - TRACK: if the inputs equal the samples and cnt == STABLE_CYCLES-1, accept the sampled pair and go to LOCKED.
  - LOCKED: hold the outputs. Any input change returns to TRACK in the same edge and clears cnt.
- Acceptance actions:
  - VALID: num <= value, num_valid <= 1. Pulse update if num_valid was 0 or value != num.
  - BLANK: num_valid <= 0; num holds; no update, no err.
  - INVALID: num_valid <= 0; num holds; pulse err; err_cnt increments unless already 255.
- clr_err: err_cnt <= 0. It wins over a simultaneous increment; the err pulse still fires.

## Timing
- Reset values:
  - num = 0, num_valid = 0, update = 0, err = 0, err_cnt = 0.
  - smp0 = smp1 = 0xFF, cnt = 0, state TRACK.
  - Held blank after reset is therefore accepted silently at the first edge where cnt reaches STABLE_CYCLES-1.
- Latency: pair presented before edge E0 and held unchanged → outputs registered at edge E(STABLE_CYCLES). Example: STABLE_CYCLES = 4 → visible after E4.
- A change at any edge before acceptance restarts the count. No partial acceptance occurs.
- update and err are single-cycle and mutually exclusive. A held pattern produces exactly one acceptance.
- Reset asserted mid-count or mid-pulse: all registers return immediately to their reset values. Pulses are never stretched across reset.

## Structure
- Shared package seg7_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants, used by both encoder and decoder.
  - The pair-class enum {PAIR_VALID, PAIR_BLANK, PAIR_INVALID}.
  - The FSM state enum.
- Sub-module seg7_digit_decode: combinational, 8-bit pattern → 4-bit digit, legal flag, blank flag. Instantiated twice, on smp0 and smp1.

## Test plan
- STABLE_CYCLES = 4. Hold led0 = 0x06, led1 = 0x24 → at E4: num = 35, num_valid = 1, update pulses once, err = 0. No further pulses while held.
- Toggle led1 between 0x24 and 0x20 every 2 cycles → no acceptance, outputs unchanged. Then hold 0x20 → num = 36 after 4 further edges.
- Hold led0 = 0x20, led1 = 0x04 (69) → err pulse, err_cnt = 1, num_valid = 0, num retains 36.
- Hold led0 = 0x7E (illegal), then 0xFF/0xFF → err_cnt increments once for 0x7E. The blank pair yields num_valid = 0 with no err.
- Force err_cnt = 255, then accept another invalid pair → err pulses, err_cnt stays 255. Assert clr_err in the same cycle as an increment → err_cnt = 0.
- Assert rst_n = 0 while cnt = 2 and num = 35 → all outputs 0 immediately. Re-accepting 35 after release pulses update.
